// File: rtl/srmt_recovery_ctrl_pkg.sv
// Shared rename types: arch/phys register tags and the recovery FSM encoding.
package rename_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PRF_W     = 6;
  localparam int IDX_W     = $clog2(ARCH_REGS / 2);

  typedef logic [4:0]       arch_reg_t;
  typedef logic [PRF_W-1:0] phys_reg_t;
  typedef logic [IDX_W-1:0] walk_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } recov_state_t;

endpackage

// File: rtl/srmt_recovery_ctrl_crmt_2w.sv
// Committed rename map: two write lanes (lane 1 wins), x0 write-ignore,
// identity reset and two combinational read ports.
module crmt_2w
  import rename_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we0_i,
  input  arch_reg_t wa0_i,
  input  phys_reg_t wd0_i,
  input  logic      we1_i,
  input  arch_reg_t wa1_i,
  input  phys_reg_t wd1_i,
  input  arch_reg_t ra0_i,
  output phys_reg_t rd0_o,
  input  arch_reg_t ra1_i,
  output phys_reg_t rd1_o
);

  phys_reg_t map_q [ARCH_REGS];
  phys_reg_t map_d [ARCH_REGS];

  // Next map: lane 0 first, then lane 1 so the younger commit overrides.
  always_comb begin
    map_d = map_q;
    if (we0_i && (wa0_i != 5'd0)) begin
      map_d[wa0_i] = wd0_i;
    end else begin
      map_d = map_d;
    end
    if (we1_i && (wa1_i != 5'd0)) begin
      map_d[wa1_i] = wd1_i;
    end else begin
      map_d = map_d;
    end
  end

  // Map storage; reset to the identity mapping x(i) -> p(i).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= phys_reg_t'(i);
      end
    end else begin
      map_q <= map_d;
    end
  end

  assign rd0_o = map_q[ra0_i];
  assign rd1_o = map_q[ra1_i];

endmodule

// File: rtl/srmt_recovery_ctrl.sv
// Recovery sequencer: holds the committed map and replays it into the speculative
// map two entries per cycle after a flush, stalling rename until the replay ends.
module srmt_recovery_ctrl
  import rename_pkg::*;
(
  input  logic      cpu_clk_i,
  input  logic      cpu_rst_ni,
  input  logic      c0_we_i,
  input  arch_reg_t c0_arch_i,
  input  phys_reg_t c0_phys_i,
  input  logic      c1_we_i,
  input  arch_reg_t c1_arch_i,
  input  phys_reg_t c1_phys_i,
  output logic      commit_ready_o,
  input  logic      flush_req_i,
  output logic      rename_stall_o,
  output logic      srmt_flush_o,
  output arch_reg_t srmt_arch0_o,
  output phys_reg_t srmt_phys0_o,
  output arch_reg_t srmt_arch1_o,
  output phys_reg_t srmt_phys1_o,
  output logic      recovery_done_o
);

  localparam walk_idx_t IDX_LAST = 4'd15;

  recov_state_t state_q, state_d;
  walk_idx_t    idx_q, idx_d;
  logic         ready_q, ready_d;
  logic         flush_q, flush_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  // Next-state and walk index; a flush request in any state (re)starts at idx 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d = WALK;
          idx_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      WALK: begin
        if (flush_req_i) begin
          state_d = WALK;
          idx_d   = 4'd0;
        end else if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = idx_q + 4'd1;
        end else begin
          idx_d   = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (flush_req_i) begin
          state_d = WALK;
          idx_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
    ready_d = (state_d == IDLE);
    flush_d = (state_d == WALK);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State, index and registered status outputs.
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      ready_q <= 1'b1;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Commits are gated by ready so the map cannot move under an in-flight walk.
  crmt_2w u_crmt (
    .clk_i  (cpu_clk_i),
    .rst_ni (cpu_rst_ni),
    .we0_i  (c0_we_i & ready_q),
    .wa0_i  (c0_arch_i),
    .wd0_i  (c0_phys_i),
    .we1_i  (c1_we_i & ready_q),
    .wa1_i  (c1_arch_i),
    .wd1_i  (c1_phys_i),
    .ra0_i  (srmt_arch0_o),
    .rd0_o  (srmt_phys0_o),
    .ra1_i  (srmt_arch1_o),
    .rd1_o  (srmt_phys1_o)
  );

  assign srmt_arch0_o    = {idx_q, 1'b0};
  assign srmt_arch1_o    = {idx_q, 1'b1};
  assign commit_ready_o  = ready_q;
  assign srmt_flush_o    = flush_q;
  assign recovery_done_o = done_q;
  assign rename_stall_o  = flush_req_i | busy_q;

endmodule
